// File: rtl/context_save_responder_pkg.sv
// Shared definitions for the context save responder: save-area geometry,
// FSM state type and the byte-address to slot decoder.
package ctx_save_pkg;

  localparam int SLOTS  = 32;
  localparam int SLOT_W = 5;
  localparam int WORD_W = 10;
  localparam logic [WORD_W-1:0] TOP_WORD = 10'h3FF;

  typedef enum logic {
    IDLE  = 1'b0,
    SCRUB = 1'b1
  } fsm_state_t;

  typedef struct packed {
    logic              valid;
    logic [SLOT_W-1:0] slot;
  } slot_dec_t;

  // Slot n sits at word TOP_WORD-n; anything outside the 32 words at the top
  // of the 8 KiB window, or not 8-byte aligned, is rejected.
  function automatic slot_dec_t addr_to_slot(input logic [63:0] addr);
    logic [WORD_W-1:0] w_diff;
    slot_dec_t         w_res;
    w_diff      = TOP_WORD - addr[12:3];
    w_res.valid = (addr[2:0] == 3'b000) && (addr[63:13] == '0) &&
                  (w_diff < WORD_W'(SLOTS));
    w_res.slot  = w_diff[SLOT_W-1:0];
    return w_res;
  endfunction

endpackage

// File: rtl/context_save_responder_if.sv
// Request/response bundle between the stacking unit (master) and the
// save-area responder (slave).
interface context_save_responder_if
  import ctx_save_pkg::*;
#(
  parameter int DATA_W = 64
);

  logic                write_signal_in;
  logic                read_signal_in;
  logic [63:0]         memory_address_in;
  logic [SLOT_W-1:0]   register_address_in;
  logic [DATA_W-1:0]   write_data_in;
  logic                clear_signal_in;
  logic [DATA_W-1:0]   read_data_out;
  logic                read_valid_out;
  logic [SLOT_W-1:0]   register_address_out;
  logic [SLOTS-1:0]    saved_flags_out;
  logic [SLOT_W:0]     saved_count_out;
  logic                busy_out;
  logic                error_out;

  modport master (
    output write_signal_in, read_signal_in, memory_address_in,
           register_address_in, write_data_in, clear_signal_in,
    input  read_data_out, read_valid_out, register_address_out,
           saved_flags_out, saved_count_out, busy_out, error_out
  );

  modport slave (
    input  write_signal_in, read_signal_in, memory_address_in,
           register_address_in, write_data_in, clear_signal_in,
    output read_data_out, read_valid_out, register_address_out,
           saved_flags_out, saved_count_out, busy_out, error_out
  );

endinterface

// File: rtl/context_save_responder_ram.sv
// Save-area storage: one write port and one registered read port.
module context_save_ram #(
  parameter  int DATA_W = 64,
  parameter  int SLOTS  = 32,
  localparam int ADDR_W = $clog2(SLOTS)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [SLOTS];
  logic [DATA_W-1:0] r_rdata;

  // NOTE: sequential state uses <= so every register samples pre-edge values;
  // the array and its read register have no reset so they map onto RAM cells.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/context_save_responder.sv
// Memory-side responder for interrupt context save/restore: decode, scrub
// FSM, saved-slot tracking and a two-stage read response pipeline.
module context_save_responder
  import ctx_save_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input logic                     clk_in,
  input logic                     rst_n_in,
  context_save_responder_if.slave bus
);

  fsm_state_t        r_state, w_state_nxt;
  logic [SLOT_W-1:0] r_ptr, w_ptr_nxt;
  logic              w_scrub_start;

  logic [SLOTS-1:0]  r_flags;
  logic [SLOT_W:0]   r_count;

  slot_dec_t         w_dec;
  logic              w_busy, w_req, w_bad, w_wr_ok, w_rd_ok;

  logic              r_s1_valid, r_s1_saved;
  logic [SLOT_W-1:0] r_s1_tag;
  logic              r_s2_valid;
  logic [DATA_W-1:0] r_s2_data;
  logic [SLOT_W-1:0] r_s2_tag;
  logic              r_err;

  logic              w_ram_we;
  logic [SLOT_W-1:0] w_ram_waddr;
  logic [DATA_W-1:0] w_ram_wdata;
  logic [DATA_W-1:0] w_ram_rdata;

  assign w_dec   = addr_to_slot(bus.memory_address_in);
  assign w_busy  = (r_state == SCRUB);
  assign w_req   = bus.write_signal_in | bus.read_signal_in;
  assign w_bad   = w_req & (w_busy | (bus.write_signal_in & bus.read_signal_in) | ~w_dec.valid);
  assign w_wr_ok = bus.write_signal_in & ~w_bad;
  assign w_rd_ok = bus.read_signal_in & ~w_bad;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // NOTE: every output of this block is defaulted first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_scrub_start = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.clear_signal_in) begin
          w_state_nxt   = SCRUB;
          w_ptr_nxt     = '0;
          w_scrub_start = 1'b1;
        end
      end
      SCRUB: begin
        w_ptr_nxt = r_ptr + SLOT_W'(1);
        if (r_ptr == SLOT_W'(SLOTS - 1)) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Requests are refused while scrubbing, so the scrub owns the write port.
  assign w_ram_we    = w_busy | w_wr_ok;
  assign w_ram_waddr = w_busy ? r_ptr : w_dec.slot;
  assign w_ram_wdata = w_busy ? '0 : bus.write_data_in;

  context_save_ram #(
    .DATA_W (DATA_W),
    .SLOTS  (SLOTS)
  ) u_ram (
    .i_clk   (clk_in),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_re    (w_rd_ok),
    .i_raddr (w_dec.slot),
    .o_rdata (w_ram_rdata)
  );

  // A clear on the same edge as a write wins: the flag is dropped again.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_flags <= '0;
      r_count <= '0;
    end else if (w_scrub_start) begin
      r_flags <= '0;
      r_count <= '0;
    end else if (w_wr_ok) begin
      r_flags[w_dec.slot] <= 1'b1;
      if (!r_flags[w_dec.slot]) r_count <= r_count + (SLOT_W + 1)'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_s1_valid <= 1'b0;
      r_s1_saved <= 1'b0;
      r_s1_tag   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_tag   <= '0;
      r_err      <= 1'b0;
    end else begin
      r_s1_valid <= w_rd_ok;
      if (w_rd_ok) begin
        r_s1_saved <= r_flags[w_dec.slot];
        r_s1_tag   <= bus.register_address_in;
      end
      r_s2_valid <= r_s1_valid;
      r_s2_data  <= (r_s1_valid && r_s1_saved) ? w_ram_rdata : '0;
      r_s2_tag   <= r_s1_valid ? r_s1_tag : '0;
      // Refused requests flag one cycle later; unsaved reads flag with their response.
      r_err      <= w_bad | (r_s1_valid & ~r_s1_saved);
    end
  end

  assign bus.read_data_out        = r_s2_data;
  assign bus.read_valid_out       = r_s2_valid;
  assign bus.register_address_out = r_s2_tag;
  assign bus.saved_flags_out      = r_flags;
  assign bus.saved_count_out      = r_count;
  assign bus.busy_out             = w_busy;
  assign bus.error_out            = r_err;

endmodule
